rgb_pwm_driver: RTL and testbench

Downstream stage of the RGB control FSM. Takes the three 8-bit channel intensities and converts them into three single-bit PWM drive signals for the LED pins, using a shared programmable-rate period counter. Duty values are double-buffered and only take effect at period boundaries, so the LEDs never glitch. The block also produces the square-wave `blink` signal that the control FSM consumes as its `pwm` input in the BLINKING state.

---
 rtl/rgb_pkg.sv | 24 ++
 rtl/pwm_channel.sv | 44 ++++
 rtl/rgb_pwm_driver.sv | 117 +++++++++++
 tb/tb_rgb_pwm_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pkg
// Purpose  : Shared constants and types for the RGB LED control path.
//            CH_W     - width of one colour channel intensity
//            PWM_LAST - last value of the PWM period counter before it wraps
//            ch_idx_t - channel index enumeration shared with the control FSM
// Revision : 1.0 - initial release
// ============================================================================
package rgb_pkg;

    localparam int CH_W = 8;

    // The period counter runs 0..254, so a duty of 255 never drops low.
    localparam logic [CH_W-1:0] PWM_LAST = 8'd254;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_idx_t;

endpackage : rgb_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM output channel: a shadow duty register that loads only
//            when told to, plus the registered compare that drives the pin.
// Ports    : clk     in  1     system clock
//            reset   in  1     asynchronous active-low reset
//            en      in  1     driver enable; low forces the output dark
//            load    in  1     shadow load strobe (period wrap or disabled)
//            duty    in  CH_W  requested intensity
//            pwm_cnt in  CH_W  shared period counter
//            led     out 1     registered PWM drive, active-high
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
    import rgb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [CH_W-1:0] duty,
    input  logic [CH_W-1:0] pwm_cnt,
    output logic            led
);

    logic [CH_W-1:0] shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            led    <= 1'b0;
        end else begin
            if (load) begin
                shadow <= duty;
            end
            // Compared against the current shadow, so a load on this edge
            // first affects the output one clock later.
            led <= en && (pwm_cnt < shadow);
        end
    end

endmodule : pwm_channel
`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Purpose  : Converts three 8-bit channel intensities into PWM pin drives
//            using a shared prescaled period counter. Duties are
//            double-buffered and switch only at period wraps. Also produces
//            a square-wave blink used by the control FSM.
// Ports    : clk          in  1  system clock
//            reset        in  1  asynchronous active-low reset
//            en           in  1  driver enable
//            prescale     in  8  tick every prescale+1 clocks
//            duty_r/g/b   in  8  requested intensities
//            led_r/g/b    out 1  registered PWM drives
//            period_start out 1  one-clock pulse at the start of each period
//            blink        out 1  square wave, BLINK_DIV periods per half
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int BLINK_DIV = 64
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [7:0]      prescale,
    input  logic [CH_W-1:0] duty_r,
    input  logic [CH_W-1:0] duty_g,
    input  logic [CH_W-1:0] duty_b,
    output logic            led_r,
    output logic            led_g,
    output logic            led_b,
    output logic            period_start,
    output logic            blink
);

    localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

    logic [7:0]      pre_cnt;
    logic [CH_W-1:0] pwm_cnt;
    logic [15:0]     blink_cnt;
    logic            tick;
    logic            wrap;
    logic            load;

    // Gating with en gives a disable priority over tick and wrap. The >=
    // compare makes a mid-count drop of prescale tick at once instead of
    // running the 8-bit counter all the way round.
    assign tick = en && (pre_cnt >= prescale);
    assign wrap = tick && (pwm_cnt == PWM_LAST);
    // While disabled the shadows track the duty inputs, so the first period
    // after enable uses the values present on the last disabled clock.
    assign load = wrap || !en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink        <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? 8'd0 : pre_cnt + 8'd1;
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
            end
            if (wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink     <= ~blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    pwm_channel u_ch_r (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .duty    (duty_r),
        .pwm_cnt (pwm_cnt),
        .led     (led_r)
    );

    pwm_channel u_ch_g (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .duty    (duty_g),
        .pwm_cnt (pwm_cnt),
        .led     (led_g)
    );

    pwm_channel u_ch_b (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .duty    (duty_b),
        .pwm_cnt (pwm_cnt),
        .led     (led_b)
    );

endmodule : rgb_pwm_driver
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_driver
// Purpose  : Self-checking bench for rgb_pwm_driver: per-period high-time
//            vectors plus reset, double-buffer, disable and blink sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_driver;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] prescale;
    logic [7:0] duty_r, duty_g, duty_b;
    logic       led_r, led_g, led_b;
    logic       period_start;
    logic       blink;

    int checks = 0;
    int errors = 0;

    // Results of the most recent measured window
    int m_len;
    int m_h[3];
    int m_first[3];
    int m_rise[3];

    typedef struct {
        logic [7:0] pre;
        logic [7:0] dr;
        logic [7:0] dg;
        logic [7:0] db;
        int         exp_len;
        int         exp_r;
        int         exp_g;
        int         exp_b;
    } vec_t;

    vec_t vecs[5];

    rgb_pwm_driver #(.BLINK_DIV(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .prescale     (prescale),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start),
        .blink        (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge on which period_start is high.
    task automatic wait_ps();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (period_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("period_start_timeout", 0, 1);
    endtask

    // Called on the negedge where period_start is seen. Samples every clock
    // up to and including the next period_start cycle; that window holds
    // exactly one period of LED output. Optionally changes duty_g mid-window.
    task automatic measure_window(input int change_at, input logic [7:0] new_g);
        logic [2:0] prev, cur;
        m_len = 0;
        for (int c = 0; c < 3; c++) begin
            m_h[c] = 0; m_first[c] = 0; m_rise[c] = 0;
        end
        prev = 3'b000;
        for (int n = 1; n <= 70000; n++) begin
            @(negedge clk);
            cur = {led_b, led_g, led_r};
            for (int c = 0; c < 3; c++) begin
                if (cur[c]) begin
                    m_h[c]++;
                    if (m_first[c] == 0) m_first[c] = n;
                    if (!prev[c]) m_rise[c]++;
                end
            end
            prev = cur;
            if (n == change_at) duty_g = new_g;
            if (period_start) begin
                m_len = n;
                break;
            end
        end
        if (m_len == 0) check("window_timeout", 0, 1);
    endtask

    // 1 when channel c was one contiguous pulse starting right after
    // period_start (or never high at all).
    function automatic int contig(input int c);
        if (m_h[c] == 0) return 1;
        return (m_rise[c] == 1 && m_first[c] == 1) ? 1 : 0;
    endfunction

    initial begin
        int ps_n, r_hi, rise_n, fall_n, wait_n;

        //            pre    r       g       b       len   r     g     b
        vecs[0] = '{8'd0, 8'd0,   8'd255, 8'd1,   255,  0,    255,  1};
        vecs[1] = '{8'd3, 8'd64,  8'd0,   8'd255, 1020, 256,  0,    1020};
        vecs[2] = '{8'd1, 8'd128, 8'd10,  8'd200, 510,  256,  20,   400};
        vecs[3] = '{8'd0, 8'd254, 8'd127, 8'd2,   255,  254,  127,  2};
        vecs[4] = '{8'd2, 8'd1,   8'd100, 8'd50,  765,  3,    300,  150};

        reset = 1'b0; en = 1'b0; prescale = 8'd0;
        duty_r = 8'd0; duty_g = 8'd0; duty_b = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_led_r", int'(led_r), 0);
        check("rst_led_g", int'(led_g), 0);
        check("rst_led_b", int'(led_b), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_blink", int'(blink), 0);

        en = 1'b1;

        // ---------------- table-driven per-period vectors ----------------
        for (int v = 0; v < 5; v++) begin
            prescale = vecs[v].pre;
            duty_r = vecs[v].dr; duty_g = vecs[v].dg; duty_b = vecs[v].db;
            wait_ps();
            measure_window(0, 8'd0);
            check($sformatf("v%0d_period_len", v), m_len, vecs[v].exp_len);
            check($sformatf("v%0d_high_r", v), m_h[0], vecs[v].exp_r);
            check($sformatf("v%0d_high_g", v), m_h[1], vecs[v].exp_g);
            check($sformatf("v%0d_high_b", v), m_h[2], vecs[v].exp_b);
            check($sformatf("v%0d_contig_r", v), contig(0), 1);
            check($sformatf("v%0d_contig_g", v), contig(1), 1);
            check($sformatf("v%0d_contig_b", v), contig(2), 1);
        end

        // ---------------- double buffering ----------------
        prescale = 8'd0; duty_r = 8'd0; duty_g = 8'd10; duty_b = 8'd0;
        wait_ps();
        measure_window(0, 8'd0);
        check("dbuf_pre_g", m_h[1], 10);
        measure_window(100, 8'd200);
        check("dbuf_mid_len", m_len, 255);
        check("dbuf_mid_g", m_h[1], 10);
        measure_window(0, 8'd0);
        check("dbuf_next_g", m_h[1], 200);
        check("dbuf_next_contig", contig(1), 1);

        // ---------------- asynchronous reset mid-period ----------------
        duty_r = 8'd128; duty_g = 8'd0;
        wait_ps();
        wait_ps();
        repeat (60) @(negedge clk);
        check("pre_reset_led_r", int'(led_r), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_led_r", int'(led_r), 0);
        check("async_rst_led_g", int'(led_g), 0);
        check("async_rst_led_b", int'(led_b), 0);
        check("async_rst_period_start", int'(period_start), 0);
        check("async_rst_blink", int'(blink), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ps_n = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (period_start) begin
                ps_n = n;
                break;
            end
        end
        check("rst_release_first_ps", ps_n, 255);

        // ---------------- disable mid-period, re-enable, blink ----------------
        duty_r = 8'd200;
        wait_ps();
        wait_ps();
        repeat (30) @(negedge clk);
        check("pre_disable_led_r", int'(led_r), 1);
        en = 1'b0;
        @(negedge clk);
        check("dis_led_r", int'(led_r), 0);
        check("dis_period_start", int'(period_start), 0);
        check("dis_blink", int'(blink), 0);
        duty_r = 8'd50;
        @(negedge clk);
        en = 1'b1;
        ps_n = 0; r_hi = 0; rise_n = 0; fall_n = 0; wait_n = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n <= 255 && led_r) r_hi++;
            if (ps_n == 0 && period_start) ps_n = n;
            if (rise_n == 0 && blink) rise_n = n;
            if (rise_n != 0 && fall_n == 0 && !blink) fall_n = n;
            if (fall_n != 0) begin
                wait_n = n;
                break;
            end
        end
        check("reen_first_ps", ps_n, 255);
        check("reen_high_r", r_hi, 50);
        check("blink_rise", rise_n, 510);
        check("blink_fall", fall_n, 1020);
        if (wait_n == 0) check("blink_timeout", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rgb_pwm_driver
`default_nettype wire
